// File: rtl/rr_arb_mux.sv
// rr_arb_mux
//
// Selects one of NUM_IN valid/ready producer channels and registers the
// winning beat into a single-entry output stage with its own valid/ready
// handshake. Arbitration is round-robin (MODE 0) or fixed priority with
// channel 0 highest (MODE 1).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    NUM_IN*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero, combinational
//   out_data   registered winning data
//   out_sel    registered index of the channel that supplied out_data
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the beat when out_valid & out_ready
module rr_arb_mux #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int MODE   = 0,
    parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;

    logic             can_load;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;

    // The output register can take a new beat when empty or when its
    // current beat leaves in this same cycle (no bubble on streaming).
    assign can_load = !out_valid_q || out_ready;

    // Grant search. In round-robin mode the scan starts at ptr_q and wraps;
    // in fixed-priority mode it always starts at channel 0.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = (MODE == 0) ? (int'(ptr_q) + k) : k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!grant_vld && in_valid[idx[SEL_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = can_load && grant_vld;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state for the output stage and the round-robin pointer.
    // The pointer moves only on a transfer, never on idle or stalled cycles.
    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (MODE == 0) begin
                if (grant_idx == SEL_W'(NUM_IN - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_idx + SEL_W'(1);
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ---- output register stage ----
    // Reset wins over a simultaneous transfer; a beat offered in the reset
    // cycle is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
